// File: rtl/alu_nibble_sequencer_pkg.sv
// Shared opcode constants and FSM encoding for the
// nibble-serial ALU sequencer.
package alu_ctrl_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        CINC = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_nibble_sequencer_if.sv
// Command and result valid/ready channels of the
// nibble-serial ALU sequencer.
interface alu_nibble_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_carry;
    logic             res_zero;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
        input  cmd_ready, res_valid, res_data, res_carry, res_zero
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
        output cmd_ready, res_valid, res_data, res_carry, res_zero
    );
endinterface

// File: rtl/alu_carry_fix.sv
// Converts the ALU's sign-extended carry (bit 4) into
// the unsigned carry-out of the 4-bit addition.
module alu_carry_fix (
    input  logic a3,
    input  logic b3,
    input  logic carry_s,
    output logic carry_u
);
    assign carry_u = carry_s ^ a3 ^ b3;
endmodule

// File: rtl/alu_nibble_sequencer.sv
// Runs WIDTH-bit add/sub/and/or one nibble at a time
// through an external combinational 4-bit ALU.
module alu_nibble_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    alu_nibble_sequencer_if.slave bus,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_opcode,
    input  logic [3:0] alu_out,
    input  logic       alu_carry
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_q, b_q, r_q, r_nx;
    logic [1:0]       op_q;
    logic             cin_q, cop_q;
    logic [IW-1:0]    idx;

    logic       arith, last, to_cinc, adv;
    logic [3:0] a_nib, b_nib, r_nib;
    logic       fa3, fb3, cu, carry_nx;

    assign arith   = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign last    = (idx == IW'(NIB - 1));
    assign to_cinc = arith && cin_q;
    assign a_nib   = a_q[{idx, 2'b00} +: 4];
    assign b_nib   = b_q[{idx, 2'b00} +: 4];
    assign r_nib   = r_q[{idx, 2'b00} +: 4];

    alu_carry_fix u_fix (
        .a3      (fa3),
        .b3      (fb3),
        .carry_s (alu_carry),
        .carry_u (cu)
    );

    always_comb begin
        state_nx      = state;
        alu_a         = '0;
        alu_b         = '0;
        alu_opcode    = '0;
        bus.cmd_ready = 1'b0;
        bus.res_valid = 1'b0;
        fa3           = 1'b0;
        fb3           = 1'b0;
        carry_nx      = 1'b0;
        adv           = 1'b0;
        r_nx          = r_q;
        r_nx[{idx, 2'b00} +: 4] = alu_out;
        unique case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) state_nx = OP;
            end
            OP: begin
                alu_a      = a_nib;
                alu_b      = b_nib;
                alu_opcode = arith ? OP_ADD : op_q;
                fa3        = a_nib[3];
                fb3        = b_nib[3];
                carry_nx   = cu;
                adv        = !to_cinc;
                if (to_cinc) state_nx = CINC;
                else         state_nx = last ? DONE : OP;
            end
            CINC: begin
                alu_a    = r_nib;
                alu_b    = 4'b0001;
                fa3      = r_nib[3];
                // OP and CINC carries are mutually exclusive
                carry_nx = cop_q | cu;
                adv      = 1'b1;
                state_nx = last ? DONE : OP;
            end
            DONE: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            r_q           <= '0;
            op_q          <= OP_ADD;
            cin_q         <= 1'b0;
            cop_q         <= 1'b0;
            idx           <= '0;
            bus.res_data  <= '0;
            bus.res_carry <= 1'b0;
            bus.res_zero  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.cmd_valid) begin
                a_q   <= bus.cmd_a;
                b_q   <= (bus.cmd_op == OP_SUB) ? ~bus.cmd_b : bus.cmd_b;
                op_q  <= bus.cmd_op;
                cin_q <= (bus.cmd_op == OP_SUB);
                idx   <= '0;
            end
            if (state == OP || state == CINC) r_q <= r_nx;
            if (state == OP && to_cinc) cop_q <= cu;
            if (adv) begin
                cin_q <= arith & carry_nx;
                if (last) begin
                    bus.res_data  <= r_nx;
                    bus.res_carry <= arith & carry_nx;
                    bus.res_zero  <= (r_nx == '0);
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer: exact 4-bit ALU model,
// arithmetic reference model and per-cycle compare.
module tb_alu_nibble_sequencer;
    import alu_ctrl_pkg::*;

    localparam int WIDTH = 8;
    localparam int NIB   = WIDTH / 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_nibble_sequencer_if #(.WIDTH(WIDTH)) bus ();

    logic [3:0] alu_a, alu_b, alu_out;
    logic [1:0] alu_opcode;
    logic       alu_carry;
    logic [4:0] alu_s;

    alu_nibble_sequencer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_out    (alu_out),
        .alu_carry  (alu_carry)
    );

    // ALU: carry is bit 4 of the sign-extended 5-bit result
    always_comb begin
        alu_s = '0;
        case (alu_opcode)
            2'b00: alu_s = {alu_a[3], alu_a} + {alu_b[3], alu_b};
            2'b01: alu_s = {alu_a[3], alu_a} - {alu_b[3], alu_b};
            2'b10: alu_s = {1'b0, alu_a & alu_b};
            default: alu_s = {1'b0, alu_a | alu_b};
        endcase
        alu_out   = alu_s[3:0];
        alu_carry = alu_s[4];
    end

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Result, carry and latency from plain integer arithmetic.
    // One CINC step happens for every nibble entered with carry-in 1.
    function automatic void model(input logic [1:0] op,
                                  input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] d, output logic c,
                                  output int lat);
        int ai, bi, s, m;
        ai  = int'(a);
        bi  = int'(b);
        lat = NIB + 1;
        d   = '0;
        c   = 1'b0;
        case (op)
            OP_ADD: begin
                s = ai + bi;
                d = s[7:0];
                c = (s >= 256);
                for (int i = 1; i < NIB; i++) begin
                    m = 1 << (4 * i);
                    if ((ai % m) + (bi % m) >= m) lat++;
                end
            end
            OP_SUB: begin
                d = a - b;
                c = (ai >= bi);
                for (int i = 0; i < NIB; i++) begin
                    m = 1 << (4 * i);
                    if ((ai % m) + ((255 - bi) % m) + 1 >= m) lat++;
                end
            end
            OP_AND: d = a & b;
            default: d = a | b;
        endcase
    endfunction

    task automatic pin(input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] ed,
                       input logic ec, input int el);
        logic [7:0] d;
        logic c;
        int l;
        model(op, a, b, d, c, l);
        chk("model_data", d, ed);
        chk("model_carry", c, ec);
        chk("model_latency", l, el);
    endtask

    logic       busy = 1'b0;
    int         cyc = 0;
    int         acc_cyc = 0;
    int         done_cnt = 0;
    logic [7:0] exp_d = '0;
    logic       exp_c = 1'b0;
    int         exp_lat = 0;
    logic [1:0] exp_op = '0;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            busy = 1'b0;
        end else if (busy) begin
            chk("cmd_ready_busy", bus.cmd_ready, 0);
            chk("res_valid_timing", bus.res_valid, (cyc - acc_cyc) >= exp_lat);
            if (bus.res_valid) begin
                chk("res_data", bus.res_data, exp_d);
                chk("res_carry", bus.res_carry, exp_c);
                chk("res_zero", bus.res_zero, exp_d == 8'h00);
                chk("alu_done_zero", {alu_a, alu_b, alu_opcode}, 0);
                if (bus.res_ready) begin
                    busy = 1'b0;
                    done_cnt++;
                end
            end else if (exp_op[1]) begin
                chk("logic_opcode", alu_opcode, exp_op);
            end
        end else begin
            chk("cmd_ready_idle", bus.cmd_ready, 1);
            chk("res_valid_idle", bus.res_valid, 0);
            chk("alu_idle_zero", {alu_a, alu_b, alu_opcode}, 0);
            if (bus.cmd_valid) begin
                busy = 1'b1;
                acc_cyc = cyc;
            end
        end
    end

    task automatic run(input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b, input int hold, input bit pulse);
        int t0, n;
        model(op, a, b, exp_d, exp_c, exp_lat);
        exp_op = op;
        t0 = done_cnt;
        bus.res_ready = (hold == 0);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op;
        bus.cmd_a = a;
        bus.cmd_b = b;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        if (pulse) begin
            repeat (3) begin
                @(posedge clk); #1;
                bus.cmd_valid = 1'b1;
                bus.cmd_op = OP_OR;
                bus.cmd_a = 8'hAA;
                @(posedge clk); #1;
                bus.cmd_valid = 1'b0;
            end
        end
        if (hold > 0) begin
            n = 0;
            while (!bus.res_valid && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            repeat (hold) @(posedge clk);
            #1 bus.res_ready = 1'b1;
        end
        n = 0;
        while (done_cnt == t0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("handshake_done", done_cnt != t0, 1);
        #1;
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op = OP_ADD;
        bus.cmd_a = '0;
        bus.cmd_b = '0;
        bus.res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_data", bus.res_data, 0);
        chk("rst_res_carry", bus.res_carry, 0);
        chk("rst_res_zero", bus.res_zero, 0);
        chk("rst_alu", {alu_a, alu_b, alu_opcode}, 0);
        reset = 1'b0;

        pin(OP_ADD, 8'h0F, 8'h01, 8'h10, 1'b0, 4);
        pin(OP_SUB, 8'h05, 8'h03, 8'h02, 1'b1, 5);
        pin(OP_SUB, 8'h03, 8'h05, 8'hFE, 1'b0, 4);
        pin(OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 4);
        pin(OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 3);
        pin(OP_OR,  8'h0A, 8'h50, 8'h5A, 1'b0, 3);

        run(OP_ADD, 8'h0F, 8'h01, 0, 1'b0);
        run(OP_SUB, 8'h05, 8'h03, 0, 1'b0);
        run(OP_SUB, 8'h03, 8'h05, 0, 1'b0);
        run(OP_ADD, 8'hFF, 8'h01, 0, 1'b0);
        run(OP_AND, 8'hF0, 8'h3C, 0, 1'b0);
        run(OP_OR,  8'h0A, 8'h50, 0, 1'b0);
        run(OP_SUB, 8'h05, 8'h03, 10, 1'b1);
        chk("hold_res_data", bus.res_data, 8'h02);
        run(OP_ADD, 8'hA7, 8'h6C, 0, 1'b0);

        // abandon a subtract while it is in the carry-increment step
        model(OP_SUB, 8'h05, 8'h03, exp_d, exp_c, exp_lat);
        exp_op = OP_SUB;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op = OP_SUB;
        bus.cmd_a = 8'h05;
        bus.cmd_b = 8'h03;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("cinc_alu_a", alu_a, 4'h1);
        chk("cinc_alu_b", alu_b, 4'h1);
        chk("cinc_alu_opcode", alu_opcode, 2'b00);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_cmd_ready", bus.cmd_ready, 1);
        chk("mid_rst_res_valid", bus.res_valid, 0);
        chk("mid_rst_alu", {alu_a, alu_b, alu_opcode}, 0);
        @(negedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_res_valid", bus.res_valid, 0);

        run(OP_ADD, 8'h0F, 8'h01, 0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no summary expected finish");
        $fatal(1);
    end
endmodule
